// File: rtl/lcd_hex_frame_ctrl.sv
// Streams one captured word to the LCD write engine as hex characters, MSB nibble first,
// preceded by a DDRAM set-address command. Optional macro LCD_CLEAR_EN adds a clear-display command first.
module lcd_hex_frame_ctrl #(
    parameter int         NUM_NIBBLES = 8,
    parameter logic [6:0] START_ADDR  = 7'h00,
    parameter int         SIZE_ASCII  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [4*NUM_NIBBLES-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [3:0]               o_hex_nibble,
    input  logic [SIZE_ASCII-1:0]    i_ascii,
    output logic [SIZE_ASCII-1:0]    o_lcd_data,
    output logic                     o_lcd_rs,
    output logic                     o_lcd_valid,
    input  logic                     i_lcd_ready,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int DATA_W = 4 * NUM_NIBBLES;
    localparam int IDX_W  = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CHAR,
        S_DONE
`ifdef LCD_CLEAR_EN
        , S_CLR
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_shadow;
    logic [IDX_W-1:0]   r_index;
    logic               w_last;
    logic               w_capture;
    logic               w_char_acc;

    assign w_last       = (r_index == IDX_W'(NUM_NIBBLES - 1));
    assign w_capture    = (r_state == S_IDLE) && i_valid;
    assign w_char_acc   = (r_state == S_CHAR) && i_lcd_ready;
    assign o_hex_nibble = r_shadow[DATA_W-1 -: 4];
    assign o_busy       = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shadow shifts left so the character being sent is always the top nibble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
            r_index  <= '0;
        end else if (w_capture) begin
            r_shadow <= i_data;
            r_index  <= '0;
        end else if (w_char_acc) begin
            r_shadow <= r_shadow << 4;
            r_index  <= w_last ? '0 : r_index + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_ready     = 1'b0;
        o_lcd_valid = 1'b0;
        o_lcd_rs    = 1'b0;
        o_lcd_data  = '0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
`ifdef LCD_CLEAR_EN
                    w_next = S_CLR;
`else
                    w_next = S_ADDR;
`endif
                end
            end
`ifdef LCD_CLEAR_EN
            S_CLR: begin
                o_lcd_data  = SIZE_ASCII'(8'h01);
                o_lcd_valid = 1'b1;
                if (i_lcd_ready) w_next = S_ADDR;
            end
`endif
            S_ADDR: begin
                o_lcd_data  = SIZE_ASCII'({1'b1, START_ADDR});
                o_lcd_valid = 1'b1;
                if (i_lcd_ready) w_next = S_CHAR;
            end
            S_CHAR: begin
                o_lcd_data  = i_ascii;
                o_lcd_rs    = 1'b1;
                o_lcd_valid = 1'b1;
                if (i_lcd_ready && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
